led_blink_scheduler: RTL and testbench
======================================

# led_blink_scheduler

Round-robin scheduler that shares the single on-board LED among `NUM_REQ` requesters. Each requester asks for a burst of N blinks at its own half-period. The scheduler grants one requester at a time, sequences the ON/OFF phases from a millisecond tick, and reports completion with a one-cycle done pulse. It sits between status sources (UART, button debouncer, error flags) and the LED pin, and replaces the free-running blinker as the LED driver.

## Interface
- `NUM_REQ`, 4 — number of requesters (2..8).
- `TICK_DIV`, 100000 — `CLK100MHZ` cycles per tick (1 ms at 100 MHz).
- `GAP_TICKS`, 500 — idle-low gap after each job, in ticks (1..65535).
- `CLK100MHZ  input  1` — system clock, all logic on rising edge.
- `CPU_RESETN  input  1` — reset; one clock; reset is asynchronous and active-low.
- `req  input  NUM_REQ` — level request per requester; held until `done` bit or abort.
- `req_count  input  4*NUM_REQ` — blinks requested, slice i = `[4i+3:4i]`.
- `req_half  input  8*NUM_REQ` — half-period in ticks, slice i = `[8i+7:8i]`.
- `grant  output  NUM_REQ` — one-hot owner of the LED, 0 when idle.
- `done  output  NUM_REQ` — one-cycle pulse on the owner's bit at normal job end.
- `busy  output  1` — high whenever state ≠ IDLE.
- `LED  output  1` — LED drive, high = on.

## Operation
- States: IDLE, ON, OFF, GAP. All outputs are registered.
- Reset values: `LED`=0, `grant`=0, `done`=0, `busy`=0, state=IDLE, RR pointer=`NUM_REQ-1` (req0 wins first), prescaler=0, phase counter=0, blinks-left=0.
- IDLE: if any `req` bit is set, pick the first set bit searching from pointer+1 upward with wrap.
  - Latch that requester's count and half; zero-half is latched as 1.
  - Set `grant`, update pointer to the winner, clear the prescaler.
  - Enter ON with `LED`=1. If the latched count is 0, enter GAP instead with `LED`=0.
- ON: `LED`=1 for `half` ticks, then go to OFF.
- OFF: `LED`=0 for `half` ticks, then decrement blinks-left.
  - If blinks-left is nonzero, go to ON.
  - Otherwise go to GAP.
- GAP: `LED`=0 for `GAP_TICKS` ticks, then go to IDLE.
  - Pulse `done[owner]` in the same cycle `grant` clears.
- Abort: if `req[owner]` drops in ON, OFF or GAP, then on the next edge `LED`=0, `grant`=0, state=IDLE, with no `done` pulse. The pointer still advances past that owner.
- Requests from non-owners are ignored while busy. There is no preemption.
- Simultaneous requests: at most one grant per IDLE visit, strictly round-robin.
- Arithmetic:
  - Prescaler: `$clog2(TICK_DIV)` bits, wraps at `TICK_DIV-1`.
  - Phase counter: 16 bits, compared against `half-1` or `GAP_TICKS-1`.
  - Blinks-left: 4 bits, never decremented below 0.

## Timing
- Latency from `req` rising in IDLE to `grant` and `LED` high: 1 cycle (registered decision).
- An ON phase is exactly `half*TICK_DIV` cycles; an OFF phase is the same.
- A GAP is `GAP_TICKS*TICK_DIV` cycles.
- Job length for count n ≥ 1: `(2*n*half + GAP_TICKS)*TICK_DIV` cycles from grant to the `done` cycle.
- After `done`, the earliest next grant is 1 cycle later, because IDLE is occupied for one cycle.
- Count 0: GAP only, so `done` comes `GAP_TICKS*TICK_DIV` cycles after grant.
- Reset asserted mid-job: all outputs go to reset values immediately (asynchronous). Release is synchronous to the next edge.

## Configuration
- `LED_SCHED_GAP_EN`
  - Defined: GAP state present as described.
  - Undefined: GAP is removed. The final OFF goes straight to IDLE with the `done` pulse, and count-0 jobs pulse `done` 1 cycle after grant. `GAP_TICKS` is ignored.

## Test plan
All scenarios use `TICK_DIV`=10, `GAP_TICKS`=3, `NUM_REQ`=4.
- Reset: hold `CPU_RESETN`=0 with req=4'b1111 → `LED`=0, `grant`=0, `busy`=0. Release → next edge `grant`=4'b0001.
- Single job: req0, count=2, half=5 → `LED` high 50, low 50, high 50, low 50 cycles, then 30 gap cycles. `done`=4'b0001 pulses 230 cycles after grant.
- Round-robin: req=4'b1011 held, each job count=1, half=1 → grant order 0, 1, 3, 0, each granted 1 cycle after the previous `done`.
- Boundaries: count=0 → no LED high, `done` after 30 cycles. half=0 → behaves as half=1 (10-cycle phases).
- Abort: drop req2 mid-ON → next edge `LED`=0, `grant`=0, no `done`. A waiting req3 is granted 1 cycle later.
- Macro undefined: same single job as above → `done` at 200 cycles, no gap.

Source files
------------

// File: rtl/led_blink_scheduler.sv
// Round-robin LED blink scheduler: one requester owns the LED per job.
// Define LED_SCHED_GAP_EN to add a GAP_TICKS idle-low gap after every job.
module led_blink_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int TICK_DIV  = 100000,
  parameter int GAP_TICKS = 500
) (
  input  logic                 CLK100MHZ,
  input  logic                 CPU_RESETN,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] req_count,
  input  logic [8*NUM_REQ-1:0] req_half,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic                 LED
);
  localparam int PW  = $clog2(NUM_REQ);
  localparam int PRW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRW-1:0] PR_LAST = PRW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PTR_RST = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  state_t             state, state_d;
  logic [PW-1:0]      ptr, ptr_d, win, cand;
  logic [PRW-1:0]     presc, presc_d;
  logic [15:0]        phase, phase_d;
  logic [3:0]         left, left_d, left_dec, win_cnt;
  logic [7:0]         half, half_d, win_half;
  logic [NUM_REQ-1:0] grant_d, done_d;
  logic               led_d, found;
  logic               tick, half_end, gap_end, abort;

`ifdef LED_SCHED_GAP_EN
  localparam logic [15:0] GAP_LAST = 16'(GAP_TICKS - 1);
  assign gap_end = tick && (phase == GAP_LAST);
`else
  logic unused_gap;
  assign unused_gap = ^GAP_TICKS;
  // Without the gap, GAP is only a one-cycle stop for count-0 jobs.
  assign gap_end = 1'b1;
`endif

  assign tick     = (presc == PR_LAST);
  assign half_end = tick && (phase == 16'(half) - 16'd1);
  assign abort    = (state != IDLE) && ((req & grant) == '0);
  assign left_dec = (left != 4'd0) ? left - 4'd1 : 4'd0;

  // First set request above the pointer, wrapping around.
  always_comb begin
    found    = 1'b0;
    win      = ptr;
    cand     = ptr;
    win_cnt  = '0;
    win_half = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == win) begin
        win_cnt  = req_count[4*i +: 4];
        win_half = req_half[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant;
    done_d  = '0;
    led_d   = LED;
    ptr_d   = ptr;
    presc_d = tick ? '0 : presc + 1'b1;
    phase_d = phase;
    left_d  = left;
    half_d  = half;
    if (abort) begin
      state_d = IDLE;
      grant_d = '0;
      led_d   = 1'b0;
      phase_d = '0;
    end else begin
      unique case (state)
        IDLE: if (found) begin
          grant_d = NUM_REQ'(1) << win;
          ptr_d   = win;
          presc_d = '0;
          phase_d = '0;
          left_d  = win_cnt;
          half_d  = (win_half == 8'd0) ? 8'd1 : win_half;
          state_d = (win_cnt != 4'd0) ? ON : GAP;
          led_d   = (win_cnt != 4'd0);
        end
        ON: begin
          if (half_end) begin
            state_d = OFF;
            led_d   = 1'b0;
            phase_d = '0;
          end else if (tick) begin
            phase_d = phase + 16'd1;
          end
        end
        OFF: begin
          if (half_end) begin
            left_d  = left_dec;
            phase_d = '0;
            if (left_dec != 4'd0) begin
              state_d = ON;
              led_d   = 1'b1;
            end else begin
`ifdef LED_SCHED_GAP_EN
              state_d = GAP;
`else
              state_d = IDLE;
              grant_d = '0;
              done_d  = grant;
`endif
            end
          end else if (tick) begin
            phase_d = phase + 16'd1;
          end
        end
        GAP: begin
          if (gap_end) begin
            state_d = IDLE;
            grant_d = '0;
            done_d  = grant;
            phase_d = '0;
          end else if (tick) begin
            phase_d = phase + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state <= IDLE;
      grant <= '0;
      done  <= '0;
      busy  <= 1'b0;
      LED   <= 1'b0;
      ptr   <= PTR_RST;
      presc <= '0;
      phase <= '0;
      left  <= '0;
      half  <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      done  <= done_d;
      busy  <= (state_d != IDLE);
      LED   <= led_d;
      ptr   <= ptr_d;
      presc <= presc_d;
      phase <= phase_d;
      left  <= left_d;
      half  <= half_d;
    end
  end
endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler: directed scenarios plus random traffic
// checked cycle by cycle against an arithmetic job-timeline model.
module tb_led_blink_scheduler;
  localparam int NR = 4;
  localparam int TD = 10;
  localparam int GT = 3;
`ifdef LED_SCHED_GAP_EN
  localparam int GC = GT * TD;
`else
  localparam int GC = 0;
`endif

  logic          CLK100MHZ = 1'b0;
  logic          CPU_RESETN = 1'b0;
  logic [3:0]    req = '0;
  logic [15:0]   req_count = '0;
  logic [31:0]   req_half = '0;
  logic [3:0]    grant, done;
  logic          busy, LED;

  led_blink_scheduler #(
    .NUM_REQ(NR), .TICK_DIV(TD), .GAP_TICKS(GT)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN),
    .req(req), .req_count(req_count), .req_half(req_half),
    .grant(grant), .done(done), .busy(busy), .LED(LED)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: a job granted at cycle g runs for len cycles; LED is high
  // in even half-period slots of the first 2*n*h*TD cycles.
  int         cyc = 0;
  bit         m_act = 0;
  int         m_own = 0, m_g = 0, m_n = 0, m_h = 1, m_len = 1, m_ptr = NR - 1;
  int         m_t;
  logic [3:0] exp_grant = '0, exp_done = '0;
  logic       exp_led = 1'b0, exp_busy = 1'b0;

  always @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      m_act = 0; m_ptr = NR - 1; cyc = 0;
      exp_grant = '0; exp_done = '0; exp_led = 0; exp_busy = 0;
    end else begin
      cyc++;
      exp_done = '0;
      if (m_act && !req[m_own]) begin
        m_act = 0; exp_grant = '0; exp_led = 0; exp_busy = 0;
      end else if (m_act && (cyc - m_g) == m_len) begin
        m_act = 0; exp_done = 4'(1 << m_own);
        exp_grant = '0; exp_led = 0; exp_busy = 0;
      end else if (m_act) begin
        m_t = cyc - m_g;
        exp_led = (m_t < 2*m_n*m_h*TD) && (((m_t / (m_h*TD)) % 2) == 0);
      end else begin
        for (int k = 1; k <= NR; k++)
          if (!m_act && req[(m_ptr + k) % NR]) begin
            m_own = (m_ptr + k) % NR;
            m_act = 1;
          end
        if (m_act) begin
          m_ptr = m_own; m_g = cyc;
          m_n = int'(req_count[4*m_own +: 4]);
          m_h = int'(req_half[8*m_own +: 8]);
          if (m_h == 0) m_h = 1;
          m_len = 2*m_n*m_h*TD + GC;
          if (m_len == 0) m_len = 1;
          exp_grant = 4'(1 << m_own); exp_busy = 1; exp_led = (m_n != 0);
        end
      end
    end
  end

  logic [9:0] obs, expv;
  assign obs  = {grant, done, busy, LED};
  assign expv = {exp_grant, exp_done, exp_busy, exp_led};

  task automatic do_reset();
    @(negedge CLK100MHZ);
    CPU_RESETN = 0; req = '0;
    repeat (2) @(negedge CLK100MHZ);
    CPU_RESETN = 1;
  endtask

  task automatic test_reset();
    @(negedge CLK100MHZ);
    CPU_RESETN = 0; req = 4'b1111;
    req_count = 16'h1111; req_half = 32'h01010101;
    repeat (3) begin
      @(negedge CLK100MHZ);
      n_cmp++;
      if ({LED, grant, busy, done} !== 10'd0) begin
        n_bad++;
        $display("FAIL reset_hold got %b want 0", {LED, grant, busy, done});
      end
    end
    CPU_RESETN = 1;
    @(negedge CLK100MHZ);
    n_cmp++;
    if (grant !== 4'b0001 || LED !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release got g=%b l=%b b=%b want 0001 1 1", grant, LED, busy);
    end
    req = '0;
    repeat (3) @(negedge CLK100MHZ);
  endtask

  task automatic test_single();
    int g0 = -1, dc = -1, hi = 0;
    do_reset();
    req_count[3:0] = 4'd2; req_half[7:0] = 8'd5; req = 4'b0001;
    for (int c = 0; c < 400 && dc < 0; c++) begin
      @(negedge CLK100MHZ);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        if (n_bad < 30) $display("FAIL single cyc=%0d got %b want %b", cyc, obs, expv);
      end
      if (grant[0] && g0 < 0) g0 = cyc;
      if (LED) hi++;
      if (done[0]) begin dc = cyc; req = '0; end
    end
    n_cmp++;
    if (dc < 0 || dc - g0 != 200 + GC) begin
      n_bad++;
      $display("FAIL single_len got %0d want %0d", dc - g0, 200 + GC);
    end
    n_cmp++;
    if (hi != 100) begin
      n_bad++;
      $display("FAIL single_led_hi got %0d want 100", hi);
    end
  endtask

  task automatic test_rr();
    int order[$];
    int gcyc[$];
    int dcyc[$];
    logic [3:0] pg = '0;
    do_reset();
    req_count = 16'h1111; req_half = 32'h01010101; req = 4'b1011;
    for (int c = 0; c < 800 && order.size() < 4; c++) begin
      @(negedge CLK100MHZ);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        if (n_bad < 30) $display("FAIL rr cyc=%0d got %b want %b", cyc, obs, expv);
      end
      if (grant != 0 && pg == 0) begin
        order.push_back($clog2(grant)); gcyc.push_back(cyc);
      end
      if (done != 0) dcyc.push_back(cyc);
      pg = grant;
    end
    req = '0;
    n_cmp++;
    if (order.size() != 4 || order[0] != 0 || order[1] != 1
        || order[2] != 3 || order[3] != 0) begin
      n_bad++;
      $display("FAIL rr_order got %p want 0 1 3 0", order);
    end
    for (int i = 1; i < gcyc.size() && i <= dcyc.size(); i++) begin
      n_cmp++;
      if (gcyc[i] != dcyc[i-1] + 1) begin
        n_bad++;
        $display("FAIL rr_gap got %0d want %0d", gcyc[i], dcyc[i-1] + 1);
      end
    end
    repeat (3) @(negedge CLK100MHZ);
  endtask

  task automatic test_boundary();
    int g0, dc, hi, first_hi;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      g0 = -1; dc = -1; hi = 0; first_hi = 0;
      if (pass == 0) begin
        req_count[7:4] = 4'd0; req_half[15:8] = 8'd7; req = 4'b0010;
      end else begin
        req_count[11:8] = 4'd1; req_half[23:16] = 8'd0; req = 4'b0100;
      end
      for (int c = 0; c < 200 && dc < 0; c++) begin
        @(negedge CLK100MHZ);
        n_cmp++;
        if (obs !== expv) begin
          n_bad++;
          if (n_bad < 30) $display("FAIL bound cyc=%0d got %b want %b", cyc, obs, expv);
        end
        if (grant != 0 && g0 < 0) g0 = cyc;
        if (LED) hi++;
        if (LED && hi == c + 1 - (g0 - cyc + c)) first_hi = hi;
        if (done != 0) begin dc = cyc; req = '0; end
      end
      n_cmp++;
      if (pass == 0 && (hi != 0 || dc - g0 != ((GC == 0) ? 1 : GC))) begin
        n_bad++;
        $display("FAIL count0 got hi=%0d len=%0d want hi=0 len=%0d",
                 hi, dc - g0, (GC == 0) ? 1 : GC);
      end
      if (pass == 1 && (hi != 10 || dc - g0 != 20 + GC)) begin
        n_bad++;
        $display("FAIL half0 got hi=%0d len=%0d want hi=10 len=%0d",
                 hi, dc - g0, 20 + GC);
      end
      @(negedge CLK100MHZ);
    end
  endtask

  task automatic test_abort();
    do_reset();
    req_count[11:8] = 4'd3; req_half[23:16] = 8'd2;
    req_count[15:12] = 4'd1; req_half[31:24] = 8'd1;
    req = 4'b1100;
    repeat (7) begin
      @(negedge CLK100MHZ);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        if (n_bad < 30) $display("FAIL abort_pre cyc=%0d got %b want %b", cyc, obs, expv);
      end
    end
    req[2] = 1'b0;
    @(negedge CLK100MHZ);
    n_cmp++;
    if (grant !== 4'b0000 || LED !== 1'b0 || done !== 4'b0000) begin
      n_bad++;
      $display("FAIL abort_drop got g=%b l=%b d=%b want 0000 0 0000", grant, LED, done);
    end
    @(negedge CLK100MHZ);
    n_cmp++;
    if (grant !== 4'b1000 || LED !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_next got g=%b l=%b want 1000 1", grant, LED);
    end
    for (int c = 0; c < 100 && req != 0; c++) begin
      @(negedge CLK100MHZ);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        if (n_bad < 30) $display("FAIL abort_post cyc=%0d got %b want %b", cyc, obs, expv);
      end
      if (done[3]) req = '0;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_count[3:0] = 4'd3; req_half[7:0] = 8'd2; req = 4'b0001;
    repeat (15) @(negedge CLK100MHZ);
    @(posedge CLK100MHZ);
    #2 CPU_RESETN = 0;
    #1;
    n_cmp++;
    if ({LED, grant, busy, done} !== 10'd0) begin
      n_bad++;
      $display("FAIL async_reset got %b want 0", {LED, grant, busy, done});
    end
    @(negedge CLK100MHZ);
    req = '0; CPU_RESETN = 1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK100MHZ);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        if (n_bad < 30) $display("FAIL random cyc=%0d got %b want %b", cyc, obs, expv);
      end
      for (int i = 0; i < NR; i++) begin
        if (done[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 19) == 0) begin
          req_count[4*i +: 4] = 4'($urandom_range(0, 3));
          req_half[8*i +: 8]  = 8'($urandom_range(0, 3));
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 399) == 0) req[i] = 1'b0;
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_boundary();
    test_abort();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
